aes_masked_sbox_collector: RTL and testbench

//   Downstream of the masked S-box output stage (GHPC gadget + output affine map)
//   in the byte-serial masked AES datapath. Delays the issue strobe by the gadget's

---
 rtl/aes_masked_sbox_collector.sv | 137 +++++++++++++
 tb/tb_aes_masked_sbox_collector.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_masked_sbox_collector.sv
// Collects the 16 two-share S-box output bytes of one AES round into a
// ShiftRows-permuted 128-bit state, keeping each share in its own register.
module aes_masked_sbox_collector #(
    parameter int unsigned LATENCY = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         sbox_issue,
    input  logic [7:0]   sbox_sh0,
    input  logic [7:0]   sbox_sh1,
    input  logic         state_ack,
    output logic [127:0] state0,
    output logic [127:0] state1,
    output logic         state_valid,
    output logic         busy,
    output logic         err_overflow,
    output logic [1:0]   dbg_state
);

    // Handshake: state0/state1 are stable while state_valid is high; a cycle
    // with state_valid && state_ack hands them over and the block returns to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t               r_state;
    logic [3:0]           r_count;
    logic [LATENCY-1:0]   r_issue_dly;
    logic [127:0]         r_state0;
    logic [127:0]         r_state1;
    logic                 r_valid;
    logic                 r_busy;
    logic                 r_err;

    logic                 w_wr_en;
    logic                 w_capture;
    logic [1:0]           w_row;
    logic [1:0]           w_col;
    logic [1:0]           w_dst_col;
    logic [3:0]           w_dst;

    assign w_wr_en   = r_issue_dly[LATENCY-1];
    assign w_capture = w_wr_en && (r_state == ST_COLLECT);

    // Destination column is (c - r) mod 4; the 2-bit subtraction wraps for free.
    assign w_row     = r_count[1:0];
    assign w_col     = r_count[3:2];
    assign w_dst_col = w_col - w_row;
    assign w_dst     = {w_dst_col, w_row};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_issue_dly <= '0;
        end else begin
            r_issue_dly[0] <= sbox_issue;
            for (int k = 1; k < int'(LATENCY); k++) begin
                r_issue_dly[k] <= r_issue_dly[k-1];
            end
        end
    end

    // Share 0 and share 1 never meet: each has its own register and only the
    // counter and capture strobe steer the write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state0 <= '0;
        end else if (w_capture) begin
            r_state0[{w_dst, 3'b000} +: 8] <= sbox_sh0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state1 <= '0;
        end else if (w_capture) begin
            r_state1[{w_dst, 3'b000} +: 8] <= sbox_sh1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_wr_en) begin
                        r_err <= 1'b1;
                    end
                    if (start) begin
                        r_state <= ST_COLLECT;
                        r_count <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_COLLECT: begin
                    if (w_wr_en) begin
                        r_count <= r_count + 4'd1;
                        if (r_count == 4'd15) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_valid <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (w_wr_en) begin
                        r_err <= 1'b1;
                    end
                    if (state_ack) begin
                        r_state <= ST_IDLE;
                        r_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign state0       = r_state0;
    assign state1       = r_state1;
    assign state_valid  = r_valid;
    assign busy         = r_busy;
    assign err_overflow = r_err;
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_aes_masked_sbox_collector.sv
// Bench for aes_masked_sbox_collector: two instances (LATENCY 1 and 3) fed through
// a behavioural S-box pipeline model, checked against a ShiftRows reference.
module tb_aes_masked_sbox_collector;

  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         start [2];
  logic         issue [2];
  logic         ack   [2];
  logic         valid [2];
  logic         busy  [2];
  logic         err   [2];
  logic [7:0]   sh0   [2];
  logic [7:0]   sh1   [2];
  logic [7:0]   stage0 [2];
  logic [7:0]   stage1 [2];
  logic [127:0] st0   [2];
  logic [127:0] st1   [2];
  logic [1:0]   dbg   [2];

  int n_checks = 0;
  int n_fail = 0;

  logic         exp_err [2];
  logic [127:0] last0 [2];
  logic [127:0] last1 [2];
  logic [127:0] in0, in1, sval;

  logic [3:0] hv [2];
  logic [7:0] h0 [2][4];
  logic [7:0] h1 [2][4];

  aes_masked_sbox_collector #(.LATENCY(LAT0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .sbox_issue(issue[0]),
    .sbox_sh0(sh0[0]), .sbox_sh1(sh1[0]), .state_ack(ack[0]),
    .state0(st0[0]), .state1(st1[0]), .state_valid(valid[0]), .busy(busy[0]),
    .err_overflow(err[0]), .dbg_state(dbg[0])
  );

  aes_masked_sbox_collector #(.LATENCY(LAT1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .sbox_issue(issue[1]),
    .sbox_sh0(sh0[1]), .sbox_sh1(sh1[1]), .state_ack(ack[1]),
    .state0(st0[1]), .state1(st1[1]), .state_valid(valid[1]), .busy(busy[1]),
    .err_overflow(err[1]), .dbg_state(dbg[1])
  );

  function automatic int lat_of(input int d);
    return (d == 0) ? LAT0 : LAT1;
  endfunction

  // ShiftRows reference: byte i (row i%4, col i/4) lands at 4*((col-row) mod 4)+row.
  function automatic logic [127:0] perm(input logic [127:0] x);
    logic [127:0] y;
    int r, c, dst;
    y = '0;
    for (int i = 0; i < 16; i++) begin
      r = i % 4;
      c = i / 4;
      dst = 4 * ((c - r + 4) % 4) + r;
      y[8*dst +: 8] = x[8*i +: 8];
    end
    return y;
  endfunction

  // S-box gadget model: shares issued with a byte appear LATENCY cycles later.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      for (int k = 3; k > 0; k--) begin
        hv[d][k] = hv[d][k-1];
        h0[d][k] = h0[d][k-1];
        h1[d][k] = h1[d][k-1];
      end
      hv[d][0] = issue[d] & rst_n;
      h0[d][0] = stage0[d];
      h1[d][0] = stage1[d];
      if (!rst_n) hv[d] = '0;
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      if (hv[d][lat_of(d)-1]) begin
        sh0[d] = h0[d][lat_of(d)-1];
        sh1[d] = h1[d][lat_of(d)-1];
      end else begin
        sh0[d] = 8'($urandom);
        sh1[d] = 8'($urandom);
      end
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_round(input int d, input int gap, input bit rnd_gap,
                          input bit poke, input bit early_ack, input bit do_ack);
    int waited;
    int bad_busy;
    int g;
    bad_busy = 0;
    @(negedge clk); start[d] = 1'b1;
    @(negedge clk); start[d] = 1'b0;
    for (int i = 0; i < 16; i++) begin
      issue[d] = 1'b1;
      stage0[d] = in0[8*i +: 8];
      stage1[d] = in1[8*i +: 8];
      if (poke && i == 8) start[d] = 1'b1;
      @(negedge clk);
      issue[d] = 1'b0;
      start[d] = 1'b0;
      stage0[d] = 8'($urandom);
      stage1[d] = 8'($urandom);
      if (busy[d] !== 1'b1) bad_busy++;
      if (i < 15) begin
        g = rnd_gap ? $urandom_range(0, 3) : gap;
        repeat (g) begin
          @(negedge clk);
          if (busy[d] !== 1'b1) bad_busy++;
        end
      end
    end
    if (early_ack) ack[d] = 1'b1;
    waited = 0;
    while (valid[d] !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("valid_rise", 128'(valid[d]), 128'(1));
    if (gap == 0 && !rnd_gap)
      check("latency", 128'(16 + waited), 128'(lat_of(d) + 16));
    check("busy_hold", 128'(bad_busy), 128'(0));
    check("busy_in_done", 128'(busy[d]), 128'(0));
    check("state0", st0[d], perm(in0));
    check("state1", st1[d], perm(in1));
    check("err_round", 128'(err[d]), 128'(exp_err[d]));
    last0[d] = perm(in0);
    last1[d] = perm(in1);
    if (early_ack) begin
      @(negedge clk);
      ack[d] = 1'b0;
      check("ack_same_cycle", 128'(valid[d]), 128'(0));
    end else if (do_ack) begin
      ack[d] = 1'b1;
      @(negedge clk);
      ack[d] = 1'b0;
      check("ack_release", 128'(valid[d]), 128'(0));
    end
  endtask

  task automatic stray(input int d, input logic exp_valid);
    @(negedge clk);
    issue[d] = 1'b1;
    stage0[d] = 8'($urandom);
    stage1[d] = 8'($urandom);
    @(negedge clk);
    issue[d] = 1'b0;
    repeat (lat_of(d) + 2) @(negedge clk);
    exp_err[d] = 1'b1;
    check("stray_err", 128'(err[d]), 128'(1));
    check("stray_state0", st0[d], last0[d]);
    check("stray_state1", st1[d], last1[d]);
    check("stray_valid", 128'(valid[d]), 128'(exp_valid));
  endtask

  task automatic new_random_round();
    in0 = {$urandom, $urandom, $urandom, $urandom};
    in1 = {$urandom, $urandom, $urandom, $urandom};
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      start[d] = 1'b0; issue[d] = 1'b0; ack[d] = 1'b0;
      stage0[d] = '0; stage1[d] = '0; sh0[d] = '0; sh1[d] = '0;
      hv[d] = '0; exp_err[d] = 1'b0; last0[d] = '0; last1[d] = '0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst_state0", st0[d], '0);
      check("rst_state1", st1[d], '0);
      check("rst_valid", 128'(valid[d]), 128'(0));
      check("rst_busy", 128'(busy[d]), 128'(0));
      check("rst_err", 128'(err[d]), 128'(0));
    end
    rst_n = 1'b1;

    // Counting bytes, constant share 1, back-to-back, LATENCY 1.
    for (int i = 0; i < 16; i++) begin
      in0[8*i +: 8] = 8'(i);
      in1[8*i +: 8] = 8'hA5;
    end
    do_round(0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("const_state0", st0[0], 128'h0b06010c07020d08030e09040f0a0500);
    check("const_state1", st1[0], {16{8'hA5}});

    // Same bytes, one issue every third cycle, LATENCY 3.
    do_round(1, 2, 1'b0, 1'b0, 1'b0, 1'b1);
    check("bubble_state0", st0[1], 128'h0b06010c07020d08030e09040f0a0500);
    check("bubble_state1", st1[1], {16{8'hA5}});
    check("bubble_err", 128'(err[1]), 128'(0));

    // Masked rounds: share 0 = sbox ^ share 1.
    for (int n = 0; n < 3; n++) begin
      sval = {$urandom, $urandom, $urandom, $urandom};
      in1 = {$urandom, $urandom, $urandom, $urandom};
      in0 = sval ^ in1;
      do_round(0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
      check("mask_unmasked", st0[0] ^ st1[0], perm(sval));
      check("mask_sh1", st1[0], perm(in1));
    end

    // Random issue gaps on the deeper pipeline.
    for (int n = 0; n < 2; n++) begin
      new_random_round();
      do_round(1, 0, 1'b1, 1'b0, 1'b0, 1'b1);
    end

    // Stray issue in IDLE, then a 17th byte while DONE.
    stray(0, 1'b0);
    new_random_round();
    do_round(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    stray(0, 1'b1);
    ack[0] = 1'b1;
    @(negedge clk);
    ack[0] = 1'b0;
    check("done_ack", 128'(valid[0]), 128'(0));
    check("err_sticky", 128'(err[0]), 128'(1));
    stray(1, 1'b0);

    // start pulsed mid-collection, ack already high when valid rises.
    new_random_round();
    do_round(0, 0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("err_after_poke", 128'(err[0]), 128'(1));

    // Reset after 8 bytes, then a clean round.
    new_random_round();
    @(negedge clk); start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      issue[0] = 1'b1;
      stage0[0] = in0[8*i +: 8];
      stage1[0] = in1[8*i +: 8];
      @(negedge clk);
    end
    issue[0] = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_state0", st0[0], '0);
    check("midrst_state1", st1[0], '0);
    check("midrst_valid", 128'(valid[0]), 128'(0));
    check("midrst_busy", 128'(busy[0]), 128'(0));
    check("midrst_err", 128'(err[0]), 128'(0));
    for (int d = 0; d < 2; d++) begin
      exp_err[d] = 1'b0;
      last0[d] = '0;
      last1[d] = '0;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    new_random_round();
    do_round(0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("post_rst_err", 128'(err[0]), 128'(0));
    new_random_round();
    do_round(1, 0, 1'b0, 1'b0, 1'b0, 1'b1);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
